dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-cycle core's data memory between the core's load/store path and a debug/loader port. It picks one requester per cycle with round-robin priority and supports an exclusive debug lock. It returns read data with a fixed one-cycle latency tagged to the winning requester, and keeps a saturating count of core stall cycles. It sits between the core's ALUOut/Readdata2/MemRead/MemWrite path and the data memory macro.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- CNT_W, 16, width of stall counter

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- core_req  in  1  core access request (MemRead|MemWrite)
- core_we  in  1  core write enable
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  core request accepted this cycle
- core_stall  out  1  core_req & ~core_gnt
- core_rvalid  out  1  core read data valid
- core_rdata  out  DATA_W  read data to core
- dbg_req  in  1  debug access request
- dbg_we  in  1  debug write enable
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_lock  in  1  debug exclusive ownership
- dbg_gnt  out  1  debug request accepted this cycle
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  DATA_W  read data to debug
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after a read strobe
- core_stall_cnt  out  CNT_W  saturating count of core stall cycles

## Operation
- Clocking: one clock `clk`. Reset `reset` is synchronous and active-high.
- Grant logic is combinational from the current requests, the `dbg_lock` input and the `rr_last` register. At most one grant is issued per cycle.
- Lock: if `dbg_lock`=1, `core_gnt`=0 and `dbg_gnt`=`dbg_req`. The lock takes effect in the same cycle it is asserted.
- Single request: if only one requester is active and the lock does not block it, that requester is granted.
- Both requesting, no lock: the requester that did not win most recently is granted, according to `rr_last`.
- `rr_last` (1 bit: 0=core, 1=dbg) updates on every grant to the winner. It holds when no grant occurs. Its reset value is 1, so the core wins the first tie.
- Memory outputs:
  - `mem_en` = `core_gnt` | `dbg_gnt`.
  - `mem_we`, `mem_addr` and `mem_wdata` are muxed from the winner.
  - With no grant, `mem_we`, `mem_addr` and `mem_wdata` are driven to 0.
- Read return: a registered 2-bit `rd_owner` captures {`dbg_gnt`&~`dbg_we`, `core_gnt`&~`core_we`}. In the next cycle `core_rvalid`/`dbg_rvalid` = `rd_owner` bits.
- Writes produce no rvalid.
- `core_rdata` and `dbg_rdata` are both wired to `mem_rdata`. Each is meaningful only while its rvalid is high.
- `core_stall_cnt` increments by 1 each cycle `core_stall`=1 and saturates at 2^CNT_W−1. It does not wrap.
- Requesters must hold their request stable until granted. The arbiter holds no pending request state.

## Timing
- Reset values, first cycle after reset:
  - `core_rvalid`=`dbg_rvalid`=0
  - `core_stall_cnt`=0
  - `rr_last`=1
  - `rd_owner`=0
- Grants and `mem_*` outputs are combinational and are 0 whenever both requests are 0.
- Latency:
  - grant is issued in the request cycle (0 cycles);
  - read data arrives exactly 1 cycle after the grant.
  - There is no back-pressure on read return.
- Back-to-back reads from alternating requesters give an rvalid every cycle, with the owner alternating.
- Reset asserted while a read is outstanding: the rvalid in the following cycle is 0. No stale return occurs after reset.
- Lock released mid-contention: in the cycle `dbg_lock` falls, normal round-robin against `rr_last` applies.
- Counter at maximum with stall still high: the counter holds the maximum value.

## Test plan
- Reset, then core read only at `core_addr`=0x10 with `mem_rdata`=0xAA:
  - `core_gnt`=1 and `mem_en`=1 with `mem_addr`=0x10 in cycle N;
  - `core_rvalid`=1 and `core_rdata`=0xAA in cycle N+1;
  - `dbg_rvalid`=0.
- Both requesters read continuously for 4 cycles after reset:
  - grants go core, dbg, core, dbg;
  - rvalid alternates core/dbg one cycle later;
  - `core_stall` is high in cycles 2 and 4, giving `core_stall_cnt`=2.
- Core write (0x20 ← 0x55) alongside a debug read:
  - the write is granted first, with `mem_we`=1 and `mem_wdata`=0x55;
  - no rvalid follows the write;
  - the debug read is granted in the next cycle.
- `dbg_lock`=1 for 5 cycles while the core requests:
  - `core_gnt`=0 and `core_stall`=1 throughout;
  - `core_stall_cnt` rises by 5;
  - the core is granted in the first cycle the lock is released and `dbg_req`=0.
- Core read granted in cycle N and `reset`=1 in cycle N+1:
  - `core_rvalid`=0 after reset;
  - all counters and `rr_last` are back at their reset values.
- With CNT_W=4, hold the core stalled for 20 cycles: `core_stall_cnt` saturates at 15 and stays there.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/grant/memory bundle between two data-memory requesters, the arbiter and the memory macro.
//   master : requester + memory side (drives requests, lock and mem_rdata)
//   slave  : arbiter side (drives grants, stall, read returns and mem_* strobes)
interface dmem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic              core_req, core_we, core_gnt, core_stall, core_rvalid;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata, core_rdata;
    logic              dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock, mem_rdata,
        input  core_gnt, core_stall, core_rvalid, core_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock, mem_rdata,
        output core_gnt, core_stall, core_rvalid, core_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin core/debug arbiter for the data memory with debug lock,
// 1-cycle tagged read return and a saturating core stall counter.
//   clk, reset     : clock, synchronous active-high reset
//   bus            : requester/grant/memory bundle (slave side)
//   core_stall_cnt : saturating count of cycles with core_req & ~core_gnt
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    dmem_arbiter_if.slave    bus,
    output logic [CNT_W-1:0] core_stall_cnt
);
    logic             rr_last_q, rr_last_d;
    logic [1:0]       rd_owner_q, rd_owner_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // rr_last_q: 0 = core won last, 1 = debug won last; a tie goes to the other one.
    always_comb begin
        bus.core_gnt    = bus.core_req & ~bus.dbg_lock & (~bus.dbg_req | rr_last_q);
        bus.dbg_gnt     = bus.dbg_req & (bus.dbg_lock | ~bus.core_req | ~rr_last_q);
        bus.core_stall  = bus.core_req & ~bus.core_gnt;
        bus.mem_en      = bus.core_gnt | bus.dbg_gnt;
        bus.mem_we      = bus.core_gnt ? bus.core_we : bus.dbg_gnt & bus.dbg_we;
        bus.mem_addr    = bus.core_gnt ? bus.core_addr : bus.dbg_gnt ? bus.dbg_addr : ADDR_W'(0);
        bus.mem_wdata   = bus.core_gnt ? bus.core_wdata : bus.dbg_gnt ? bus.dbg_wdata : DATA_W'(0);
        bus.core_rvalid = rd_owner_q[0];
        bus.dbg_rvalid  = rd_owner_q[1];
        bus.core_rdata  = bus.mem_rdata;
        bus.dbg_rdata   = bus.mem_rdata;
        core_stall_cnt  = stall_cnt_q;
    end

    always_comb begin
        rr_last_d   = bus.core_gnt ? 1'b0 : bus.dbg_gnt ? 1'b1 : rr_last_q;
        rd_owner_d  = {bus.dbg_gnt & ~bus.dbg_we, bus.core_gnt & ~bus.core_we};
        stall_cnt_d = (bus.core_stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_q   <= 1'b1;
            rd_owner_q  <= 2'b00;
            stall_cnt_q <= '0;
        end else begin
            rr_last_q   <= rr_last_d;
            rd_owner_q  <= rd_owner_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus randomized checks of dmem_arbiter against a behavioural model.
module tb_dmem_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic        core_req = 0, core_we = 0, dbg_req = 0, dbg_we = 0, dbg_lock = 0;
    logic [31:0] core_addr = 0, core_wdata = 0, dbg_addr = 0, dbg_wdata = 0, mem_rdata = 0;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;
    int          checks = 0, failures = 0;

    // model state: who won last (1 core, 2 dbg), pending read returns, stall counters
    int m_last, m_cnt16, m_cnt4;
    bit m_rv_core, m_rv_dbg;

    dmem_arbiter_if bus ();
    dmem_arbiter_if bus4 ();

    assign bus.core_req = core_req;   assign bus4.core_req = core_req;
    assign bus.core_we = core_we;     assign bus4.core_we = core_we;
    assign bus.core_addr = core_addr; assign bus4.core_addr = core_addr;
    assign bus.core_wdata = core_wdata; assign bus4.core_wdata = core_wdata;
    assign bus.dbg_req = dbg_req;     assign bus4.dbg_req = dbg_req;
    assign bus.dbg_we = dbg_we;       assign bus4.dbg_we = dbg_we;
    assign bus.dbg_addr = dbg_addr;   assign bus4.dbg_addr = dbg_addr;
    assign bus.dbg_wdata = dbg_wdata; assign bus4.dbg_wdata = dbg_wdata;
    assign bus.dbg_lock = dbg_lock;   assign bus4.dbg_lock = dbg_lock;
    assign bus.mem_rdata = mem_rdata; assign bus4.mem_rdata = mem_rdata;

    dmem_arbiter dut (.clk(clk), .reset(reset), .bus(bus), .core_stall_cnt(cnt16));
    dmem_arbiter #(.CNT_W(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4), .core_stall_cnt(cnt4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 2; m_rv_core = 0; m_rv_dbg = 0; m_cnt16 = 0; m_cnt4 = 0;
    endtask

    // One clock cycle: check outputs for the inputs currently applied, then advance the model.
    task automatic cyc();
        int w;
        logic [31:0] ea, ed;
        logic ewe;
        #2;
        if (dbg_lock) w = dbg_req ? 2 : 0;
        else if (core_req && dbg_req) w = (m_last == 2) ? 1 : 2;
        else w = core_req ? 1 : dbg_req ? 2 : 0;
        ea  = (w == 1) ? core_addr : (w == 2) ? dbg_addr : 32'h0;
        ed  = (w == 1) ? core_wdata : (w == 2) ? dbg_wdata : 32'h0;
        ewe = (w == 1) ? core_we : (w == 2) ? dbg_we : 1'b0;
        chk("core_gnt", bus.core_gnt, w == 1);
        chk("dbg_gnt", bus.dbg_gnt, w == 2);
        chk("core_stall", bus.core_stall, core_req && w != 1);
        chk("mem_en", bus.mem_en, w != 0);
        chk("mem_we", bus.mem_we, ewe);
        chk("mem_addr", bus.mem_addr, ea);
        chk("mem_wdata", bus.mem_wdata, ed);
        chk("core_rvalid", bus.core_rvalid, m_rv_core);
        chk("dbg_rvalid", bus.dbg_rvalid, m_rv_dbg);
        if (m_rv_core) chk("core_rdata", bus.core_rdata, mem_rdata);
        if (m_rv_dbg) chk("dbg_rdata", bus.dbg_rdata, mem_rdata);
        chk("stall_cnt16", cnt16, m_cnt16);
        chk("stall_cnt4", cnt4, m_cnt4);
        chk("core_gnt4", bus4.core_gnt, w == 1);
        chk("dbg_gnt4", bus4.dbg_gnt, w == 2);
        @(posedge clk);
        if (reset) model_reset();
        else begin
            if (core_req && w != 1) begin
                m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : m_cnt16;
                m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : m_cnt4;
            end
            m_rv_core = (w == 1) && !core_we;
            m_rv_dbg  = (w == 2) && !dbg_we;
            if (w != 0) m_last = w;
        end
        #1;
    endtask

    task automatic idle();
        core_req = 0; dbg_req = 0; core_we = 0; dbg_we = 0; dbg_lock = 0;
    endtask

    initial begin
        int base;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_core_rvalid", bus.core_rvalid, 0);
        chk("rst_dbg_rvalid", bus.dbg_rvalid, 0);
        chk("rst_cnt", cnt16, 0);
        chk("rst_rr_last", dut.rr_last_q, 1);
        reset = 0;

        // core read 0x10, memory returns 0xAA next cycle
        core_req = 1; core_addr = 32'h10; mem_rdata = 32'hAA;
        cyc();
        idle();
        chk("rd_rvalid", bus.core_rvalid, 1);
        chk("rd_rdata", bus.core_rdata, 32'hAA);
        chk("rd_dbg_rvalid", bus.dbg_rvalid, 0);
        cyc();

        // both read for 4 cycles after reset: core, dbg, core, dbg
        reset = 1; cyc(); reset = 0;
        core_req = 1; dbg_req = 1; core_addr = 32'h100; dbg_addr = 32'h200;
        repeat (4) cyc();
        chk("alt_cnt", cnt16, 2);
        idle(); cyc();

        // core write alongside debug read
        core_req = 1; core_we = 1; core_addr = 32'h20; core_wdata = 32'h55;
        dbg_req = 1; dbg_addr = 32'h30; mem_rdata = 32'h77;
        cyc();
        core_req = 0; core_we = 0;
        chk("wr_no_rvalid", bus.core_rvalid, 0);
        cyc();
        dbg_req = 0;
        chk("dbg_rd_rvalid", bus.dbg_rvalid, 1);
        cyc();

        // lock for 5 cycles while core requests
        base = int'(cnt16);
        core_req = 1; core_addr = 32'h40; dbg_req = 1; dbg_lock = 1; dbg_addr = 32'h44;
        repeat (5) cyc();
        chk("lock_cnt", cnt16, base + 5);
        dbg_lock = 0; dbg_req = 0;
        cyc();
        idle(); cyc();

        // reset while a read is outstanding
        core_req = 1; core_addr = 32'h50; dbg_req = 0;
        cyc();
        idle(); reset = 1;
        cyc();
        reset = 0;
        chk("rst_rd_rvalid", bus.core_rvalid, 0);
        chk("rst_rd_cnt", cnt16, 0);
        chk("rst_rd_rr", dut.rr_last_q, 1);
        cyc();

        // saturation of the 4-bit counter
        core_req = 1; dbg_lock = 1;
        repeat (20) cyc();
        chk("sat_cnt4", cnt4, 15);
        chk("sat_cnt16", cnt16, 20);
        idle(); cyc();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            core_req   = ($urandom_range(0, 3) != 0);
            dbg_req    = ($urandom_range(0, 2) != 0);
            core_we    = $urandom_range(0, 1);
            dbg_we     = $urandom_range(0, 1);
            dbg_lock   = ($urandom_range(0, 7) == 0);
            reset      = ($urandom_range(0, 49) == 0);
            core_addr  = $urandom; dbg_addr = $urandom;
            core_wdata = $urandom; dbg_wdata = $urandom;
            mem_rdata  = $urandom;
            cyc();
        end
        reset = 0; idle(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
